// File: rtl/multiword_add_seq.sv
// multiword_add_seq: wide unsigned adder that reuses one N-bit add slice over
// WORDS cycles, least-significant word first, rippling the carry between words.
// busy marks the RUN phase, done pulses for one cycle when sum/carry are final.
module multiword_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N*WORDS-1:0] termA,
    input  logic [N*WORDS-1:0] termB,
    input  logic               carry_in,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] sum,
    output logic               carry
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [WORDS-1:0][N-1:0] r_a;
    logic [WORDS-1:0][N-1:0] r_b;
    logic [WORDS-1:0][N-1:0] r_sum;
    logic                    r_c;
    logic                    r_carry;
    logic [IDX_W-1:0]        r_idx;

    logic                    w_accept;
    logic                    w_last;
    logic [N-1:0]            w_a_word;
    logic [N-1:0]            w_b_word;
    logic [N:0]              w_add;

    // A new request is taken only when no operation is in flight.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_idx == IDX_W'(WORDS - 1));

    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign sum   = r_sum;
    assign carry = r_carry;

    // Select the current operand words and add them with the chained carry.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        w_a_word = '0;
        w_b_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_word = r_a[i];
                w_b_word = r_b[i];
            end
        end
        w_add = {1'b0, w_a_word} + {1'b0, w_b_word} + (N + 1)'(r_c);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN lasts WORDS cycles, DONE lasts exactly one.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then fill one sum word per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand and sum word registers are reset too, so an abort
        // mid-operation leaves no partial result or stale operand behind.
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_c     <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= termA;
            r_b     <= termB;
            r_c     <= carry_in;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            for (int i = 0; i < WORDS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_sum[i] <= w_add[N-1:0];
                end
            end
            r_c <= w_add[N];
            if (w_last) begin
                r_carry <= w_add[N];
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq: a WORDS=4 instance covering the main
// sequences and a WORDS=1 instance for the single-cycle corner.
module tb_multiword_add_seq;

    localparam int N = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] term_a;
    logic [31:0] term_b;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        carry;

    logic        s1_start;
    logic [7:0]  s1_a;
    logic [7:0]  s1_b;
    logic        s1_cin;
    logic        s1_busy;
    logic        s1_done;
    logic [7:0]  s1_sum;
    logic        s1_carry;

    int n_checks = 0;
    int n_errors = 0;

    multiword_add_seq #(.N(N), .WORDS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .termA    (term_a),
        .termB    (term_b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry)
    );

    multiword_add_seq #(.N(N), .WORDS(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (s1_start),
        .termA    (s1_a),
        .termB    (s1_b),
        .carry_in (s1_cin),
        .busy     (s1_busy),
        .done     (s1_done),
        .sum      (s1_sum),
        .carry    (s1_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, let it be accepted, then scramble the operand inputs.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin);
        start    = 1'b1;
        term_a   = a;
        term_b   = b;
        carry_in = cin;
        step();
        start    = 1'b0;
        term_a   = 32'hDEAD_BEEF;
        term_b   = 32'hCAFE_F00D;
        carry_in = 1'b1;
    endtask

    // Called just after the accepting edge: expects 4 busy cycles then done.
    task automatic expect_op(input string tag, input logic [31:0] exp_sum, input logic exp_carry);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, {busy, done}, 2'b10);
            step();
        end
        check({tag, "_done"}, {busy, done}, 2'b01);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_carry"}, carry, exp_carry);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        term_a   = '0;
        term_b   = '0;
        carry_in = 1'b0;
        s1_start = 1'b0;
        s1_a     = '0;
        s1_b     = '0;
        s1_cin   = 1'b0;

        #3;
        check("reset_flags", {busy, done}, 2'b00);
        check("reset_sum", sum, 32'h0);
        check("reset_carry", carry, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_flags", {busy, done}, 2'b00);

        // 0xFF + 0x01: single carry into word 1.
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0);
        expect_op("t1", 32'h0000_0100, 1'b0);
        step();
        check("t1_idle_flags", {busy, done}, 2'b00);
        check("t1_hold_sum", sum, 32'h0000_0100);

        // Carry ripples through every word and out the top.
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        expect_op("t2", 32'h0000_0000, 1'b1);
        step();
        check("t2_hold_carry", carry, 1'b1);

        // carry_in participates; start re-pulsed mid-RUN must be ignored.
        issue(32'h1234_5678, 32'h1111_1111, 1'b1);
        check("t3_cleared_carry", carry, 1'b0);
        check("t3_busy0", {busy, done}, 2'b10);
        step();
        start  = 1'b1;
        term_a = 32'hFFFF_FFFF;
        check("t3_busy1", {busy, done}, 2'b10);
        step();
        start  = 1'b0;
        check("t3_busy2", {busy, done}, 2'b10);
        step();
        check("t3_busy3", {busy, done}, 2'b10);
        step();
        check("t3_done", {busy, done}, 2'b01);
        check("t3_sum", sum, 32'h2345_678A);
        check("t3_carry", carry, 1'b0);

        // Back-to-back: start held during the DONE cycle of the first op.
        step();
        issue(32'h0000_0010, 32'h0000_0020, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("b2b_last_run", {busy, done}, 2'b10);
        start    = 1'b1;
        term_a   = 32'h0000_0002;
        term_b   = 32'h0000_0003;
        carry_in = 1'b0;
        step();
        check("b2b_first_done", {busy, done}, 2'b01);
        check("b2b_first_sum", sum, 32'h0000_0030);
        step();
        start    = 1'b0;
        term_a   = 32'hDEAD_BEEF;
        term_b   = 32'hCAFE_F00D;
        check("b2b_sum_cleared", sum, 32'h0);
        expect_op("b2b", 32'h0000_0005, 1'b0);

        // Asynchronous reset while idx=2, between clock edges.
        step();
        issue(32'h1111_1111, 32'h2222_2222, 1'b0);
        step();
        step();
        check("ar_partial_sum", sum, 32'h0000_3333);
        check("ar_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_flags", {busy, done}, 2'b00);
        check("ar_sum", sum, 32'h0);
        check("ar_carry", carry, 1'b0);
        step();
        #2;
        rst_n = 1'b1;
        step();
        check("ar_idle_after", {busy, done}, 2'b00);
        issue(32'h8000_0000, 32'h8000_0000, 1'b0);
        expect_op("ar_new", 32'h0000_0000, 1'b1);

        // WORDS=1 instance: done two edges after the accepting one's cycle.
        step();
        s1_start = 1'b1;
        s1_a     = 8'hFF;
        s1_b     = 8'h01;
        s1_cin   = 1'b1;
        step();
        s1_start = 1'b0;
        s1_a     = 8'h00;
        s1_b     = 8'h00;
        s1_cin   = 1'b0;
        check("w1_busy", {s1_busy, s1_done}, 2'b10);
        step();
        check("w1_done", {s1_busy, s1_done}, 2'b01);
        check("w1_sum", s1_sum, 8'h01);
        check("w1_carry", s1_carry, 1'b1);
        step();
        check("w1_idle", {s1_busy, s1_done}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Sequencer that performs a wide (N*WORDS-bit) addition by reusing one N-bit add datapath over WORDS cycles, chaining carry word to word (least-significant word first).
- Sits between a requester issuing start/operands and downstream logic consuming sum/carry on done.
- Trades area for latency relative to a full-width combinational adder.

Parameters:
- N, 8, word width in bits of the shared add datapath.
- WORDS, 4, number of words per operand (>=1); total operand width is N*WORDS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only in IDLE or DONE state.
- termA  input  N*WORDS  operand A; sampled on the accepting edge only.
- termB  input  N*WORDS  operand B; sampled on the accepting edge only.
- carry_in  input  1  carry into word 0; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  N*WORDS  result; registered.
- carry  output  1  carry out of the most-significant word; registered.

Behaviour:
- Reset: asynchronous, rst_n low forces state=IDLE, busy=0, done=0, sum=0, carry=0, word index=0, operand registers=0. This applies at any time, including mid-RUN; the operation is aborted with no partial result retained.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture termA, termB, carry_in into internal registers; clear sum; set index=0; go to RUN. start=0 -> stay.
  - RUN: each cycle compute {c, w} = A[idx] + B[idx] + carry_reg (N+1-bit result, no truncation of c). Write w into sum word idx and carry_reg <= c. If idx==WORDS-1 -> go to DONE and drive carry <= c. Otherwise idx <= idx+1.
  - DONE: done=1 for exactly this cycle. start=1 -> accept new operands exactly as in IDLE and go to RUN, so done and the new busy are contiguous. start=0 -> go to IDLE.
- Handshake rules:
  - busy=1 exactly in RUN, WORDS cycles per operation.
  - start while in RUN is ignored; no queuing.
  - Operand inputs may change freely after the accepting edge.
- Latency: start sampled high at edge t -> busy high in cycles t+1..t+WORDS -> done high in cycle t+WORDS+1.
- Output holding:
  - sum and carry hold their final values through DONE and IDLE until the next accepted start.
  - On an accepted start, sum and carry are cleared to 0.
  - During RUN, sum words fill progressively; they are not valid until done.
- Arithmetic: unsigned, modulo 2^(N*WORDS), with carry reporting overflow. carry_in participates as +1 at the LSB.
- Index counter width: max(1, clog2(WORDS)). WORDS=1 gives a single RUN cycle and done at t+2.

Test Plan:
- N=8, WORDS=4, termA=0x000000FF, termB=0x00000001, carry_in=0, start at t -> busy t+1..t+4, done at t+5, sum=0x00000100, carry=0.
- termA=0xFFFFFFFF, termB=0x00000001, carry_in=0 -> carry ripples through all words; sum=0x00000000, carry=1.
- termA=0x12345678, termB=0x11111111, carry_in=1 -> sum=0x2345678A, carry=0; start re-pulsed during RUN with termA=0xFFFFFFFF gives no change to result or timing.
- Back-to-back: second start (termA=0x00000002, termB=0x00000003) held high during the DONE cycle of the first operation -> done then busy in consecutive cycles; second result sum=0x00000005 at DONE+5.
- rst_n driven low asynchronously during RUN (idx=2) -> busy, done, sum, carry go to 0 immediately without a clock edge. After release, a new start with 0x80000000+0x80000000 gives sum=0x00000000, carry=1.
- WORDS=1 build: termA=0xFF, termB=0x01, carry_in=1 -> done at t+2, sum=0x01, carry=1.
